// File: rtl/ds_pkg.sv
// ds_pkg: bus codes, state encoding and widths shared by the
// 2x2 downsampling sequencer and its datapath neighbours.
package ds_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] CB_NONE = 4'b0000;
  localparam logic [3:0] CB_SOR  = 4'b1001;
  localparam logic [2:0] AB_NONE = 3'b000;
  localparam logic [2:0] AB_SOR  = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RD,
    S_INC,
    S_EMIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/ds_sor_sequencer.sv
// ds_sor_sequencer: walks the four source taps of each 2x2 output
// pixel through SOR, handshaking memory reads and averaged results.
module ds_sor_sequencer #(
  parameter int DATA_W = ds_pkg::DATA_W,
  parameter int DIM_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] src_base,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  output logic [3:0]        cbus_en,
  output logic [DATA_W-1:0] cbus_data,
  output logic              sor_inc,
  output logic [2:0]        abus_en,
  output logic              mem_rd_req,
  input  logic              mem_rd_ack,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  import ds_pkg::*;

  state_t state, state_n;

  logic [DATA_W-1:0] row_ptr, row_ptr_n;
  logic [DATA_W-1:0] p, p_n, tgt;
  logic [DATA_W-1:0] w_ext, row_step;
  logic [DIM_W-1:0]  w_q, w_n, h_q, h_n;
  logic [DIM_W-1:0]  col, col_n, row, row_n;
  logic [DIM_W-1:0]  w_in, h_in;
  logic [DIM_W-1:0]  col_last, row_last;
  logic [1:0]        tap, tap_n;
  logic              rd_done, out_hs;

  assign w_in     = img_w & ~DIM_W'(1);
  assign h_in     = img_h & ~DIM_W'(1);
  assign w_ext    = DATA_W'(w_q);
  assign row_step = row_ptr + (w_ext << 1);
  assign col_last = (w_q >> 1) - DIM_W'(1);
  assign row_last = (h_q >> 1) - DIM_W'(1);

  assign rd_done = mem_rd_req & mem_rd_ack;
  assign out_hs  = out_valid & out_ready;
  assign acc_en  = rd_done;
  assign acc_clr = rd_done & (tap == 2'd0);

  always_comb begin
    state_n   = state;
    row_ptr_n = row_ptr;
    p_n       = p;
    w_n       = w_q;
    h_n       = h_q;
    col_n     = col;
    row_n     = row;
    tap_n     = tap;
    tgt       = '0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          w_n       = w_in;
          h_n       = h_in;
          row_ptr_n = src_base;
          p_n       = src_base;
          col_n     = '0;
          row_n     = '0;
          tap_n     = '0;
          tgt       = src_base;
          if (w_in < DIM_W'(2) || h_in < DIM_W'(2))
            state_n = S_DONE;
          else
            state_n = S_LOAD;
        end
      end
      S_LOAD: state_n = S_RD;
      S_RD: begin
        if (rd_done) begin
          tap_n = tap + 2'd1;
          unique case (tap)
            2'd1: begin
              state_n = S_LOAD;
              tgt     = p + w_ext;
            end
            2'd3:    state_n = S_EMIT;
            default: state_n = S_INC;
          endcase
        end
      end
      S_INC: state_n = S_RD;
      S_EMIT: begin
        if (out_hs) begin
          if (col < col_last) begin
            col_n   = col + DIM_W'(1);
            p_n     = p + DATA_W'(2);
            tgt     = p + DATA_W'(2);
            state_n = S_LOAD;
          end else if (row < row_last) begin
            col_n     = '0;
            row_n     = row + DIM_W'(1);
            row_ptr_n = row_step;
            p_n       = row_step;
            tgt       = row_step;
            state_n   = S_LOAD;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // outputs are decoded from the next state so they appear as flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      row_ptr    <= '0;
      p          <= '0;
      w_q        <= '0;
      h_q        <= '0;
      col        <= '0;
      row        <= '0;
      tap        <= '0;
      cbus_en    <= CB_NONE;
      cbus_data  <= '0;
      sor_inc    <= 1'b0;
      abus_en    <= AB_NONE;
      mem_rd_req <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      row_ptr    <= row_ptr_n;
      p          <= p_n;
      w_q        <= w_n;
      h_q        <= h_n;
      col        <= col_n;
      row        <= row_n;
      tap        <= tap_n;
      cbus_en    <= (state_n == S_LOAD) ? CB_SOR : CB_NONE;
      cbus_data  <= (state_n == S_LOAD) ? tgt : '0;
      sor_inc    <= (state_n == S_INC);
      abus_en    <= (state_n == S_RD) ? AB_SOR : AB_NONE;
      mem_rd_req <= (state_n == S_RD);
      out_valid  <= (state_n == S_EMIT);
      busy       <= (state_n != S_IDLE);
      done       <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_ds_sor_sequencer.sv
// tb_ds_sor_sequencer: randomized frames against a tap-address model,
// with a SOR model and a negedge scoreboard monitor.
module tb_ds_sor_sequencer;

  import ds_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_base;
  logic [15:0] img_w, img_h;
  logic [3:0]  cbus_en;
  logic [31:0] cbus_data;
  logic        sor_inc;
  logic [2:0]  abus_en;
  logic        mem_rd_req, mem_rd_ack;
  logic        acc_clr, acc_en;
  logic        out_valid, out_ready;
  logic        busy, done;
  logic        ack_raw = 1'b0;
  logic        rdy_raw = 1'b0;

  assign mem_rd_ack = ack_raw & ~rst;
  assign out_ready  = rdy_raw & ~rst;

  ds_sor_sequencer #(.DATA_W(32), .DIM_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_base(src_base), .img_w(img_w), .img_h(img_h),
    .cbus_en(cbus_en), .cbus_data(cbus_data),
    .sor_inc(sor_inc), .abus_en(abus_en),
    .mem_rd_req(mem_rd_req), .mem_rd_ack(mem_rd_ack),
    .acc_clr(acc_clr), .acc_en(acc_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [31:0] exp_addr_q[$];
  int req_len_q[$];
  int vld_len_q[$];
  int n_exp = 0;
  int ack_mode = 0;
  int rdy_mode = 0;
  int extra_ack = 0;
  int extra_rdy = 0;

  // memory side: hold ack low for a chosen number of cycles per read
  int ack_left = 0;
  bit ack_busy = 0;
  always @(posedge clk) begin
    #1;
    if (mem_rd_req && !rst) begin
      if (!ack_busy) begin
        ack_busy = 1;
        if (ack_mode == 1) ack_left = 3;
        else if (ack_mode == 2) ack_left = int'($urandom_range(0, 3));
        else ack_left = 0;
        extra_ack += ack_left;
        req_len_q.push_back(ack_left + 1);
      end
      if (ack_left == 0) begin
        ack_raw = 1'b1;
        ack_busy = 0;
      end else begin
        ack_raw = 1'b0;
        ack_left--;
      end
    end else begin
      ack_raw = 1'b0;
      ack_busy = 0;
    end
  end

  int fread = 0;
  int fout = 0;

  int rdy_left = 0;
  bit rdy_busy = 0;
  always @(posedge clk) begin
    #1;
    if (out_valid && !rst) begin
      if (!rdy_busy) begin
        rdy_busy = 1;
        if (rdy_mode == 1) rdy_left = (fout == 1) ? 5 : 0;
        else if (rdy_mode == 2) rdy_left = int'($urandom_range(0, 3));
        else rdy_left = 0;
        extra_rdy += rdy_left;
        vld_len_q.push_back(rdy_left + 1);
      end
      if (rdy_left == 0) begin
        rdy_raw = 1'b1;
        rdy_busy = 0;
      end else begin
        rdy_raw = 1'b0;
        rdy_left--;
      end
    end else begin
      rdy_raw = 1'b0;
      rdy_busy = 0;
    end
  end

  logic [31:0] sor_m = '0;
  logic [31:0] ea;
  int req_cyc = 0;
  int val_cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int ea0 = 0;
  int er0 = 0;
  int act_cnt;
  bit rd;
  bit frame_on = 0;

  always @(negedge clk) begin
    if (rst) begin
      frame_on = 0;
      req_cyc = 0;
      val_cyc = 0;
    end else begin
      if (start && !busy && !frame_on) begin
        frame_on = 1;
        start_cyc = cyc;
        fread = 0;
        fout = 0;
        ea0 = extra_ack;
        er0 = extra_rdy;
        req_cyc = 0;
        val_cyc = 0;
      end
      if (busy) begin
        act_cnt = int'(cbus_en != CB_NONE) + int'(sor_inc)
                + int'(mem_rd_req) + int'(out_valid);
        chk("one_action", act_cnt, done ? 0 : 1);
        chk("abus_en", abus_en, mem_rd_req ? AB_SOR : AB_NONE);
        if (cbus_en != CB_NONE) chk("cbus_code", cbus_en, CB_SOR);
        else chk("cbus_idle", cbus_data, 0);
      end else begin
        chk("idle_quiet", {cbus_en, cbus_data, sor_inc, abus_en,
                           mem_rd_req, out_valid, done}, 0);
      end
      rd = mem_rd_req && mem_rd_ack;
      chk("acc", {acc_en, acc_clr}, {rd, rd && (fread % 4 == 0)});
      if (mem_rd_req) req_cyc++;
      if (rd) begin
        chk("rd_pending", exp_addr_q.size(), exp_addr_q.size() ? 
            exp_addr_q.size() : 1);
        if (exp_addr_q.size() > 0) begin
          ea = exp_addr_q.pop_front();
          chk("rd_addr", sor_m, ea);
        end
        if (req_len_q.size() > 0)
          chk("rd_wait", req_cyc, req_len_q.pop_front());
        fread++;
        req_cyc = 0;
      end
      if (out_valid) val_cyc++;
      if (out_valid && out_ready) begin
        chk("emit_reads", fread, 4 * (fout + 1));
        if (vld_len_q.size() > 0)
          chk("valid_hold", val_cyc, vld_len_q.pop_front());
        fout++;
        val_cyc = 0;
      end
      if (done) begin
        chk("frame_cycles", cyc - start_cyc + 1,
            2 + 9 * n_exp + (extra_ack - ea0) + (extra_rdy - er0));
        chk("frame_outputs", fout, n_exp);
        frame_on = 0;
        done_cnt++;
      end
    end
    if (cbus_en == CB_SOR) sor_m = cbus_data;
    else if (sor_inc) sor_m = sor_m + 32'd1;
  end

  task automatic setup(input logic [31:0] base, input int w,
                       input int h);
    int wd, ht;
    wd = w & ~1;
    ht = h & ~1;
    exp_addr_q.delete();
    req_len_q.delete();
    vld_len_q.delete();
    n_exp = (wd >= 2 && ht >= 2) ? (wd / 2) * (ht / 2) : 0;
    if (n_exp > 0) begin
      for (int r = 0; r < ht / 2; r++) begin
        for (int c = 0; c < wd / 2; c++) begin
          logic [31:0] a;
          a = base + 32'(2 * r * wd + 2 * c);
          exp_addr_q.push_back(a);
          exp_addr_q.push_back(a + 32'd1);
          exp_addr_q.push_back(a + 32'(wd));
          exp_addr_q.push_back(a + 32'(wd) + 32'd1);
        end
      end
    end
    src_base = base;
    img_w = 16'(w);
    img_h = 16'(h);
  endtask

  task automatic run_frame(input logic [31:0] base, input int w,
                           input int h, input int am, input int rm,
                           input bit mid);
    int d0;
    bit ok;
    setup(base, w, h);
    ack_mode = am;
    rdy_mode = rm;
    d0 = done_cnt;
    ok = 0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #2;
      start = (mid && i == 8);
      if (done_cnt > d0) begin
        ok = 1;
        break;
      end
    end
    start = 1'b0;
    chk("frame_done", ok, 1);
    if (ok) begin
      chk("done_pulse", {done, busy}, 2'b00);
      chk("addr_left", exp_addr_q.size(), 0);
    end
  endtask

  task automatic reset_test();
    bit hit;
    hit = 0;
    setup(32'h100, 4, 4);
    ack_mode = 0;
    rdy_mode = 0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (mem_rd_req && fread == 2) begin
        hit = 1;
        break;
      end
    end
    chk("rst_hit", hit, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_outs", {cbus_en, cbus_data, sor_inc, abus_en, mem_rd_req,
                     acc_en, acc_clr, out_valid, busy, done}, 0);
    rst = 1'b0;
    run_frame(32'h100, 4, 4, 0, 0, 0);
  endtask

  initial begin
    src_base = '0;
    img_w = '0;
    img_h = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {cbus_en, cbus_data, sor_inc, abus_en, mem_rd_req,
                        acc_en, acc_clr, out_valid, busy, done}, 0);
    rst = 1'b0;
    run_frame(32'h100, 4, 4, 0, 0, 0);
    run_frame(32'h100, 4, 4, 1, 0, 0);
    run_frame(32'h100, 4, 4, 0, 1, 0);
    run_frame(32'h100, 1, 8, 0, 0, 0);
    reset_test();
    run_frame(32'hFFFF_FFFE, 4, 2, 0, 0, 1);
    for (int k = 0; k < 12; k++) begin
      run_frame($urandom, int'($urandom_range(0, 12)),
                int'($urandom_range(0, 10)), 2, 2, (k % 3) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ds_sor_sequencer.md
# ds_sor_sequencer

Address sequencer for the 2×2 downsampling pass. It drives the source-address register (SOR) through its cbus load code and `inc_en`, and places SOR on the A-bus for each memory read. It walks the four source taps of every output pixel, handshakes each read with memory and each result with the averaging/write-back path, and pulses `done` at the end of the frame.

## Interface
- `DATA_W`, 32: address / cbus width
- `DIM_W`, 16: width of image dimension ports
- `clk`  in  1: rising-edge clock (SOR itself captures on the falling edge)
- `rst`  in  1: reset, synchronous, active-high
- `start`  in  1: begin a frame; sampled only in IDLE
- `src_base`  in  DATA_W: address of source pixel (0,0)
- `img_w`, `img_h`  in  DIM_W: source width/height in pixels; LSB ignored (floor to even)
- `cbus_en`  out  4: `CB_SOR` (4'b1001) in LOAD, else `CB_NONE` (4'b0000)
- `cbus_data`  out  DATA_W: value to load into SOR; 0 when not loading
- `sor_inc`  out  1: drives SOR `inc_en`
- `abus_en`  out  3: `AB_SOR` (3'b001) in RD, else `AB_NONE` (3'b000)
- `mem_rd_req` / `mem_rd_ack`  out/in  1: read handshake; a read completes in any cycle where both are high
- `acc_clr`, `acc_en`  out  1: accumulator control; `acc_en` high on each completed read, `acc_clr` additionally high on tap 0
- `out_valid` / `out_ready`  out/in  1: result handshake
- `busy`  out  1: high in every state except IDLE
- `done`  out  1: one-cycle pulse at frame end

## Operation
- States: IDLE, LOAD, RD, INC, EMIT, DONE.
- Registers:
  - `row_ptr`: base + 2·r·W
  - `p`: current top-left tap address
  - `tap` (2 bits), `col`, `row`
  - latched `W = img_w & ~1`, `H = img_h & ~1`
- IDLE: on `start`, latch inputs and set `row_ptr = p = src_base`, `col = row = tap = 0`.
  - If W<2 or H<2: go to DONE (no reads).
  - Otherwise: go to LOAD with target p.
- LOAD (1 cycle): `cbus_en = CB_SOR`, `cbus_data = target`. Next state RD.
- RD: `mem_rd_req = 1`, `abus_en = AB_SOR`, held until ack. On ack, leave by tap:
  - tap0 → INC
  - tap1 → LOAD with target p+W
  - tap2 → INC
  - tap3 → EMIT
  - `tap` increments on each completed read.
- INC (1 cycle): `sor_inc = 1`. Next state RD.
- Tap addresses per output: p, p+1, p+W, p+W+1.
- EMIT: `out_valid = 1` until `out_ready`. On handshake:
  - If `col < W/2-1`: `col++`, `p += 2`, go to LOAD.
  - Else if `row < H/2-1`: `col = 0`, `row++`, `row_ptr += 2W`, `p = row_ptr + 2W`, go to LOAD.
  - Else: go to DONE.
- DONE: `done = 1` for one cycle, then IDLE.
- Invariants:
  - `cbus_en = CB_SOR` and `sor_inc` are never high in the same cycle.
  - All address arithmetic is modulo 2^DATA_W (wraps silently).
- `start` outside IDLE is ignored; no queuing.
- Reset: all outputs 0 (`cbus_en = 4'b0000`, `abus_en = 3'b000`), state IDLE, counters 0.
  - Reset mid-frame abandons the frame: no `done`, no `out_valid`.
  - SOR contents are left to SOR's own reset.

## Timing
- All outputs are registered on the rising edge.
- A LOAD/INC asserted at rising edge k is captured by SOR at the falling edge inside cycle k; SOR is stable on the A-bus at edge k+1, when RD begins.
- Per output with zero-wait ack and ready: 9 cycles (LOAD, RD, INC, RD, LOAD, RD, INC, RD, EMIT).
- Frame time with zero-wait handshakes: 2 + 9·(W/2)·(H/2) cycles, from the `start` edge to the `done` pulse inclusive.
- While `mem_rd_ack` is low, SOR and all sequencer state are held.
- While `out_ready` is low, `out_valid` is held and nothing else changes.

## Structure
- Shared package `ds_pkg` holds:
  - bus codes `CB_NONE`, `CB_SOR = 4'b1001`, `AB_NONE`, `AB_SOR = 3'b001`
  - state enum typedef
  - `DATA_W`
- Single module, no sub-modules. The next-address adder (p/row_ptr update) stays inline.

## Test plan
- 4×4 frame, `src_base` 0x100, zero-wait handshakes → reads at 0x100, 0x101, 0x104, 0x105, then 0x102, 0x103, 0x106, 0x107, then 0x108…, ending at 0x10F. Exactly 16 reads and 4 `out_valid` handshakes; `done` at cycle 38.
- Same frame with `mem_rd_ack` delayed 3 cycles on every read → `mem_rd_req` and `abus_en` held, no `sor_inc`/`cbus_en` while waiting, address order unchanged.
- `out_ready` low for 5 cycles at output 2 → `out_valid` held 6 cycles; next LOAD target 0x108 only after the handshake.
- `img_w = 1`, `img_h = 8`, `start` → `busy` for 1 cycle, `done` pulse, zero reads.
- `rst` asserted during the RD of output 1, tap 2 → next cycle: IDLE, all outputs 0, no `done`. A fresh `start` then replays the full sequence from 0x100.
- `src_base` 0xFFFF_FFFE, 4×2 frame → tap addresses wrap to 0xFFFF_FFFF, 0x0000_0002, 0x0000_0003. `start` pulsed mid-frame is ignored.
